// File: rtl/ysyx_22050598_regfile_scb_pkg.sv
// ysyx_22050598_regfile_scb_pkg: shared constants, address-width helper and pend-counter type for the register file scoreboard.
package ysyx_22050598_regfile_scb_pkg;
    localparam int REG_ZERO   = 0;
    localparam int REG_A0     = 10;
    localparam int PEND_W_DEF = 2;

    typedef logic [PEND_W_DEF-1:0] pend_t;

    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ysyx_22050598_rf_pend_cnt.sv
// ysyx_22050598_rf_pend_cnt: saturating outstanding-writer counter; simultaneous inc and dec hold the count.
module ysyx_22050598_rf_pend_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_full
);
    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_full = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_inc && !i_dec && !o_full)
            r_cnt <= r_cnt + W'(1);
        else if (i_dec && !i_inc && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end
endmodule

// File: rtl/ysyx_22050598_regfile_scb.sv
// ysyx_22050598_regfile_scb: register file with per-register write-pending scoreboard.
// Define YSYX_22050598_RF_BYPASS_EN to forward the retiring write-back onto read ports.
module ysyx_22050598_regfile_scb
    import ysyx_22050598_regfile_scb_pkg::*;
#(
    parameter  int XLEN   = 64,
    parameter  int NREG   = 32,
    parameter  int NRD    = 2,
    parameter  int PEND_W = 2,
    localparam int AW     = addr_w(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ren,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [XLEN-1:0]     ebreak_a0
);
    logic [XLEN-1:0]   r_rf [NREG];
    logic [PEND_W-1:0] w_pend [NREG];
    logic [NREG-1:0]   w_full;
    logic              w_wr;
    logic              w_acc;

    assign w_wr      = wen && waddr != AW'(REG_ZERO);
    // A retiring write to the same register frees the slot the reservation takes.
    assign rsv_ready = rsv_addr == AW'(REG_ZERO) || !w_full[rsv_addr] || (wen && waddr == rsv_addr);
    assign w_acc     = rsv_valid && rsv_ready && !flush && rsv_addr != AW'(REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst)
            for (int n = 0; n < NREG; n++) r_rf[n] <= '0;
        else if (w_wr)
            r_rf[waddr] <= wdata;
    end

    assign w_pend[0] = '0;
    assign w_full[0] = 1'b0;

    genvar k;
    for (k = 1; k < NREG; k++) begin : g_cnt
        ysyx_22050598_rf_pend_cnt #(.W(PEND_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .i_inc  (w_acc && rsv_addr == AW'(k)),
            .i_dec  (w_wr && waddr == AW'(k)),
            .i_clr  (flush),
            .o_cnt  (w_pend[k]),
            .o_full (w_full[k])
        );
    end

    assign dbg_data  = r_rf[dbg_addr];
    assign ebreak_a0 = r_rf[REG_A0];

    genvar i;
    for (i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_en;
        assign w_a  = raddr[i*AW +: AW];
        assign w_en = ren && w_a != AW'(REG_ZERO);
`ifdef YSYX_22050598_RF_BYPASS_EN
        logic w_hit;
        assign w_hit                 = w_en && wen && waddr == w_a;
        assign rdata[i*XLEN +: XLEN] = !w_en ? '0 : w_hit ? wdata : r_rf[w_a];
        assign rbusy[i]              = w_en && (w_hit ? (w_pend[w_a] - PEND_W'(1)) != '0 : w_pend[w_a] != '0);
`else
        assign rdata[i*XLEN +: XLEN] = w_en ? r_rf[w_a] : '0;
        assign rbusy[i]              = w_en && w_pend[w_a] != '0;
`endif
    end
endmodule

// File: tb/tb_ysyx_22050598_regfile_scb.sv
// tb_ysyx_22050598_regfile_scb: directed plus randomized checks against an array-based reference model.
module tb_ysyx_22050598_regfile_scb;
    localparam int XLEN = 64, NREG = 32, NRD = 2, AW = 5, PMAX = 3;

    logic                clk = 1'b0;
    logic                rst, ren, wen, rsv_valid, flush, rsv_ready;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [AW-1:0]       waddr, rsv_addr, dbg_addr;
    logic [XLEN-1:0]     wdata, dbg_data, ebreak_a0;

    ysyx_22050598_regfile_scb dut (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_ready(rsv_ready), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .ebreak_a0(ebreak_a0)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] m_rf [NREG];
    int              m_p  [NREG];
    int              n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return rsv_addr == 0 || m_p[rsv_addr] < PMAX || (wen && waddr == rsv_addr);
    endfunction

    task automatic check_outs();
        for (int p = 0; p < NRD; p++) begin
            int a;
            a = int'(raddr[p*AW +: AW]);
            chk($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], (ren && a != 0) ? m_rf[a] : 64'd0);
            chk($sformatf("rbusy%0d", p), 64'(rbusy[p]), 64'(ren && a != 0 && m_p[a] != 0));
        end
        chk("rsv_ready", 64'(rsv_ready), 64'(m_ready()));
        chk("dbg_data", dbg_data, m_rf[dbg_addr]);
        chk("ebreak_a0", ebreak_a0, m_rf[10]);
    endtask

    task automatic model_tick();
        logic acc;
        acc = rsv_valid && m_ready() && rsv_addr != 0;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin m_rf[r] = '0; m_p[r] = 0; end
        end else begin
            if (wen && waddr != 0) m_rf[waddr] = wdata;
            if (flush) begin
                for (int r = 0; r < NREG; r++) m_p[r] = 0;
            end else if (!(acc && wen && waddr == rsv_addr)) begin
                if (acc) m_p[rsv_addr]++;
                if (wen && waddr != 0 && m_p[waddr] > 0) m_p[waddr]--;
            end
        end
    endtask

    task automatic set_in(input logic r, input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic we, input logic [AW-1:0] wa, input logic [63:0] wd,
                          input logic rv, input logic [AW-1:0] ra, input logic fl, input logic [AW-1:0] da);
        rst = r; ren = re; raddr = {a1, a0}; wen = we; waddr = wa; wdata = wd;
        rsv_valid = rv; rsv_addr = ra; flush = fl; dbg_addr = da;
        #1 check_outs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin m_rf[r] = '0; m_p[r] = 0; end
        rst = 1; ren = 0; raddr = '0; wen = 0; waddr = '0; wdata = '0;
        rsv_valid = 0; rsv_addr = '0; flush = 0; dbg_addr = '0;
        @(posedge clk);
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        // write x5 then read it on both ports
        set_in(0, 0, 0, 0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0); tick();
        set_in(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("x5_p0", rdata[63:0], 64'hDEAD_BEEF);
        chk("x5_p1", rdata[127:64], 64'hDEAD_BEEF);
        chk("x5_busy", 64'(rbusy), 64'd0);
        tick();
        // x0 write and reserve are ignored
        set_in(0, 1, 0, 5, 1, 0, 64'h1234, 1, 0, 0, 0);
        chk("x0_ready", 64'(rsv_ready), 64'd1);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_data", rdata[63:0], 64'd0);
        chk("x0_busy", 64'(rbusy[0]), 64'd0);
        tick();
        // saturate x7
        for (int n = 0; n < 3; n++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
            chk("x7_ready_n", 64'(rsv_ready), 64'd1);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        chk("x7_full", 64'(rsv_ready), 64'd0);
        tick();
        set_in(0, 0, 0, 0, 1, 7, 64'h77, 1, 7, 0, 0);
        chk("x7_retire_ready", 64'(rsv_ready), 64'd1);
        tick();
        set_in(0, 1, 7, 0, 0, 0, 0, 0, 7, 0, 0);
        chk("x7_still_busy", 64'(rbusy[0]), 64'd1);
        chk("x7_still_full", 64'(rsv_ready), 64'd0);
        tick();
        // read-after-write-back without bypass
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); tick();
        set_in(0, 1, 3, 0, 1, 3, 64'h55, 0, 0, 0, 0);
        chk("x3_old", rdata[63:0], 64'd0);
        chk("x3_busy", 64'(rbusy[0]), 64'd1);
        tick();
        set_in(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x3_new", rdata[63:0], 64'h55);
        chk("x3_free", 64'(rbusy[0]), 64'd0);
        tick();
        // flush drops everything including same-cycle reservation
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0); tick();
        set_in(0, 1, 4, 9, 0, 0, 0, 1, 6, 1, 0);
        chk("pre_flush_busy", 64'(rbusy), 64'd3);
        tick();
        set_in(0, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_x4_x9", 64'(rbusy), 64'd0);
        tick();
        set_in(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_x6", 64'(rbusy[0]), 64'd0);
        tick();
        // a0 debug taps and reset
        set_in(0, 0, 0, 0, 1, 10, 64'h1, 0, 0, 0, 10); tick();
        set_in(0, 0, 10, 10, 0, 0, 0, 0, 0, 0, 10);
        chk("ren0_data", rdata, 128'd0);
        chk("a0_tap", ebreak_a0, 64'h1);
        chk("dbg_a0", dbg_data, 64'h1);
        tick();
        set_in(1, 0, 0, 0, 1, 10, 64'h9, 1, 10, 1, 10); tick();
        set_in(0, 1, 10, 7, 0, 0, 0, 0, 7, 0, 10);
        chk("rst_a0", ebreak_a0, 64'd0);
        chk("rst_dbg", dbg_data, 64'd0);
        chk("rst_busy", 64'(rbusy), 64'd0);
        chk("rst_ready", 64'(rsv_ready), 64'd1);
        tick();
        // randomized traffic concentrated on a few registers
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a0, a1, wa, ra, da;
            a0 = AW'($urandom_range(0, 7));
            a1 = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wa = AW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 7));
            da = AW'(($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 31));
            set_in($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, a0, a1,
                   $urandom_range(0, 2) == 0, wa, {$urandom, $urandom},
                   $urandom_range(0, 1) == 1, ra, $urandom_range(0, 29) == 0, da);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22050598_regfile_scb.md
# ysyx_22050598_regfile_scb

Parametrised integer register file with an attached write-pending scoreboard for the pipelined core. It provides NRD combinational read ports, one synchronous write-back port, a per-register outstanding-writer counter with a reserve handshake, optional write-to-read bypass, and debug taps (a0 and an arbitrary register). It sits between decode/issue, which reads operands and reserves rd, and write-back, which retires results.

## Interface
- XLEN, 64, register width
- NREG, 32, register count (power of two); AW = log2(NREG)
- NRD, 2, number of read ports
- PEND_W, 2, pending-counter width; max outstanding writers per register = 2^PEND_W − 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ren  in  1  global read enable
- raddr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  packed read data
- rbusy  out  NRD  port i operand has an outstanding writer
- wen  in  1  write-back valid
- waddr  in  AW  write-back address
- wdata  in  XLEN  write-back data
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  AW  destination register being reserved
- rsv_ready  out  1  reservation can be accepted this cycle
- flush  in  1  pipeline flush: discard all reservations
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  rf[dbg_addr], no bypass
- ebreak_a0  out  XLEN  rf[10], no bypass

## Operation
- Register 0 reads 0, is never written, never reserved, never busy.
- Write: wen && waddr != 0 → rf[waddr] <= wdata; pend[waddr] decrements (floor 0; decrement at 0 is a no-op, no underflow).
- Reserve: accepted when rsv_valid && rsv_ready && !flush && rsv_addr != 0 → pend[rsv_addr] increments.
- rsv_ready = 1 when rsv_addr == 0 or pend[rsv_addr] < max, or when a write to rsv_addr retires this cycle (net count unchanged). Otherwise 0; issue must stall.
- Reserve and write to the same register in the same cycle: net pend unchanged.
- flush: all pend counters cleared to 0 next edge; a write in the same cycle still updates rf; reservation in the same cycle is dropped.
- Read port i: ren == 0 or raddr_i == 0 → rdata_i = 0, rbusy_i = 0. Otherwise rdata_i = rf[raddr_i], rbusy_i = (pend[raddr_i] != 0) (bypass rules under Configuration).
- Reads are combinational; rsv_ready depends combinationally on rsv_addr, pend, wen, and waddr only, not on rsv_valid.

## Timing
- Read latency 0 (combinational). Write visible to non-bypassed reads the cycle after the wen edge.
- Reservation visible on rbusy the cycle after acceptance.
- Reset: all rf entries = 0, all pend = 0. Next cycle: rdata = 0, rbusy = 0, rsv_ready = 1, dbg_data = 0, ebreak_a0 = 0. Reset overrides wen, rsv_valid, and flush in the same cycle.
- Reset asserted mid-stream discards all pending state; no partial updates.

## Configuration
- YSYX_22050598_RF_BYPASS_EN defined: on a read-port hit (wen && waddr == raddr_i != 0):
  - rdata_i = wdata.
  - rbusy_i = (pend[raddr_i] − 1) != 0, so the last outstanding writer retiring this cycle yields a not-busy, valid operand.
- Undefined: no bypass; read data and busy flag reflect registered state only (one extra cycle of stall on read-after-write-back).
- Debug taps are never bypassed in either build.

## Structure
- Shared package: AW derivation helper, register index constants (REG_ZERO = 0, REG_A0 = 10), and a pend-counter typedef parameterised on PEND_W.
- One sub-module: ysyx_22050598_rf_pend_cnt, a single saturating up/down counter with inc, dec, clr, and a full flag, instantiated NREG−1 times (index 0 tied off).
- Read ports built with a generate loop over NRD.

## Test plan
- Reset, then write x5 = 0xDEAD_BEEF and read x5 on ports 0 and 1 next cycle → both return 0xDEAD_BEEF, rbusy = 0; read x0 → 0.
- Write x0 = 0x1234, reserve x0 → x0 reads 0, rbusy = 0, rsv_ready = 1, pend unchanged.
- Reserve x7 three times (PEND_W = 2) → rsv_ready = 0 on the fourth attempt. Write x7 in the same cycle as that attempt → rsv_ready = 1 and the count stays 3.
- Bypass build: pend[x3] = 1, wen x3 = 0x55 while reading x3 → rdata = 0x55, rbusy = 0. Non-bypass build: rdata = old value, rbusy = 1, then 0x55 with rbusy = 0 the next cycle.
- Reserve x4 and x9, assert flush with a reservation of x6 in the same cycle → next cycle x4, x6, and x9 all have rbusy = 0.
- Write a0 = 0x1 with ren = 0 → rdata = 0 on all ports, ebreak_a0 = 0x1, dbg_data with dbg_addr = 10 returns 0x1; assert rst → all outputs return to 0 the next cycle.
